dmem_responder: RTL and testbench

- Memory-side responder for the core's load/store requests; the slave end of the data-memory request interface.
- Accepts one request at a time over a valid/ready handshake and holds a word-organised internal SRAM array.
- Returns a response after a programmable latency.
- Replaces the simulation-only memory access path with synthesizable RTL for multi-cycle core bring-up.

---
 rtl/dmem_responder.sv | 127 ++++++++++++
 tb/tb_dmem_responder.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time over valid/ready, word-organised
// SRAM, response after a programmable wait, byte-lane aligned reads and writes.
module dmem_responder #(
  parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 4096,
  parameter int          LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wmask,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int IW = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [3:0]  cnt;
  logic        c_wen;
  logic [31:0] c_addr;
  logic [31:0] c_wdata;
  logic [3:0]  c_wmask;

  logic [31:0] mem [DEPTH_WORDS];

  logic          accept;
  logic          enter_resp;
  logic [31:0]   rel;
  logic          in_range;
  logic [1:0]    off;
  logic [IW-1:0] idx;
  logic [7:0]    eff;
  logic [31:0]   wshift;
  logic          err_c;
  logic          commit;

  // Address decode and lane alignment all work from the captured request.
  always_comb begin
    rel      = c_addr - ADDR_BASE;
    in_range = (c_addr >= ADDR_BASE) && ({1'b0, rel} < SPAN);
    off      = c_addr[1:0];
    idx      = IW'(rel >> 2);
    eff      = {4'b0, c_wmask} << off;
    wshift   = c_wdata << {off, 3'b000};
    err_c    = !in_range || (c_wen && (|eff[7:4]));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = WAIT;
      WAIT:    if (cnt == 4'd0) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == IDLE) && !rst;
    rsp_valid  = (state == RESP);
    accept     = req_ready && req_valid;
    enter_resp = (state == WAIT) && (cnt == 4'd0);
    commit     = enter_resp && c_wen && !err_c;
  end

  // WAIT always lasts LATENCY+1 cycles, so rsp_valid rises LATENCY+1 edges after accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= 4'd0;
      c_wen   <= 1'b0;
      c_addr  <= 32'd0;
      c_wdata <= 32'd0;
      c_wmask <= 4'd0;
    end else begin
      if (accept) begin
        cnt     <= 4'(LATENCY);
        c_wen   <= req_wen;
        c_addr  <= req_addr;
        c_wdata <= req_wdata;
        c_wmask <= req_wmask;
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else if (enter_resp) begin
      rsp_err   <= err_c;
      rsp_rdata <= (!c_wen && !err_c) ? (mem[idx] >> {off, 3'b000}) : 32'd0;
    end
  end

  // Array has no reset; a faulting write commits nothing.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (eff[i]) mem[idx][8*i +: 8] <= wshift[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances at LATENCY 2, 0 and 15.
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst       [3];
  logic        req_valid [3];
  logic        req_ready [3];
  logic        req_wen   [3];
  logic [31:0] req_addr  [3];
  logic [31:0] req_wdata [3];
  logic [3:0]  req_wmask [3];
  logic        rsp_valid [3];
  logic        rsp_ready [3];
  logic [31:0] rsp_rdata [3];
  logic        rsp_err   [3];

  int n_assert = 0;
  int n_fail   = 0;

  dmem_responder #(.LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_wen(req_wen[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .req_wmask(req_wmask[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]));

  dmem_responder #(.LATENCY(0)) u_l0 (
    .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_wen(req_wen[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .req_wmask(req_wmask[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]));

  dmem_responder #(.LATENCY(15)) u_l15 (
    .clk(clk), .rst(rst[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_wen(req_wen[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
    .req_wmask(req_wmask[2]), .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]),
    .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full transaction; hold>0 keeps rsp_ready low for that many cycles after rsp_valid.
  task automatic xact(input int s, input logic wen, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] mask, input int hold,
                      output logic [31:0] rdata, output logic err, output int lat);
    int w;
    @(negedge clk);
    req_valid[s] = 1'b1;
    req_wen[s]   = wen;
    req_addr[s]  = addr;
    req_wdata[s] = wdata;
    req_wmask[s] = mask;
    rsp_ready[s] = (hold == 0);
    w = 0;
    while (!req_ready[s] && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!req_ready[s]) check("accept_timeout", 32'(req_ready[s]), 32'd1);
    @(posedge clk);
    #1;
    req_valid[s] = 1'b0;
    req_addr[s]  = 32'h0BAD_0000;
    req_wdata[s] = 32'h5555_5555;
    req_wmask[s] = 4'hF;
    lat = 0;
    while (!rsp_valid[s] && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    rdata = rsp_rdata[s];
    err   = rsp_err[s];
    if (hold > 0) begin
      for (int h = 0; h < hold; h++) begin
        @(posedge clk);
        #1;
        check("bp_rsp_valid", 32'(rsp_valid[s]), 32'd1);
        check("bp_rsp_rdata", rsp_rdata[s], rdata);
        check("bp_rsp_err",   32'(rsp_err[s]), 32'(err));
        check("bp_req_ready", 32'(req_ready[s]), 32'd0);
      end
      rsp_ready[s] = 1'b1;
    end
    @(posedge clk);
    #1;
    check("post_rsp_valid", 32'(rsp_valid[s]), 32'd0);
    check("post_req_ready", 32'(req_ready[s]), 32'd1);
  endtask

  always @(negedge clk) begin
    for (int s = 0; s < 3; s++) begin
      if (!rst[s]) begin
        n_assert++;
        assert (!(req_ready[s] && rsp_valid[s])) else begin
          n_fail++;
          $error("FAIL overlap inst %0d: req_ready=%b rsp_valid=%b, required not both 1",
                 s, req_ready[s], rsp_valid[s]);
        end
      end
    end
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lt;

    for (int s = 0; s < 3; s++) begin
      rst[s]       = 1'b1;
      req_valid[s] = 1'b0;
      req_wen[s]   = 1'b0;
      req_addr[s]  = 32'd0;
      req_wdata[s] = 32'd0;
      req_wmask[s] = 4'd0;
      rsp_ready[s] = 1'b0;
    end
    #2;
    check("rst_req_ready", 32'(req_ready[0]), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    check("rst_rsp_rdata", rsp_rdata[0], 32'd0);
    check("rst_rsp_err",   32'(rsp_err[0]), 32'd0);
    @(negedge clk);
    @(negedge clk);
    for (int s = 0; s < 3; s++) rst[s] = 1'b0;
    @(negedge clk);
    check("idle_req_ready", 32'(req_ready[0]), 32'd1);

    // Full-word write then aligned/unaligned reads
    xact(0, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, rd, er, lt);
    check("wr10_lat", 32'(lt), 32'd3);
    check("wr10_err", 32'(er), 32'd0);
    check("wr10_rdata", rd, 32'd0);
    xact(0, 1'b0, 32'h8000_0010, 32'd0, 4'h0, 0, rd, er, lt);
    check("rd10", rd, 32'hDEAD_BEEF);
    check("rd10_err", 32'(er), 32'd0);
    check("rd10_lat", 32'(lt), 32'd3);
    xact(0, 1'b0, 32'h8000_0011, 32'd0, 4'h0, 0, rd, er, lt);
    check("rd11", rd, 32'h00DE_ADBE);
    xact(0, 1'b0, 32'h8000_0013, 32'd0, 4'h0, 0, rd, er, lt);
    check("rd13", rd, 32'h0000_00DE);

    // Byte and half lanes
    xact(0, 1'b1, 32'h8000_0020, 32'hCAFE_F00D, 4'hF, 0, rd, er, lt);
    xact(0, 1'b1, 32'h8000_0022, 32'h0000_00AB, 4'h1, 0, rd, er, lt);
    check("wrbyte_err", 32'(er), 32'd0);
    xact(0, 1'b0, 32'h8000_0020, 32'd0, 4'h0, 0, rd, er, lt);
    check("rd20_byte", rd, 32'hCAAB_F00D);
    xact(0, 1'b1, 32'h8000_0022, 32'h0000_1234, 4'h3, 0, rd, er, lt);
    xact(0, 1'b0, 32'h8000_0020, 32'd0, 4'h0, 0, rd, er, lt);
    check("rd20_half", rd, 32'h1234_F00D);

    // Range errors on both sides of the window
    xact(0, 1'b0, 32'h7FFF_FFFC, 32'd0, 4'h0, 0, rd, er, lt);
    check("below_err", 32'(er), 32'd1);
    check("below_rdata", rd, 32'd0);
    xact(0, 1'b0, 32'h8000_0010, 32'd0, 4'h0, 0, rd, er, lt);
    xact(0, 1'b0, 32'h8000_4000, 32'd0, 4'h0, 0, rd, er, lt);
    check("above_err", 32'(er), 32'd1);
    check("above_rdata", rd, 32'd0);
    xact(0, 1'b0, 32'h8000_3FFC, 32'd0, 4'h0, 0, rd, er, lt);
    check("last_word_err", 32'(er), 32'd0);

    // Word-crossing write must commit nothing
    xact(0, 1'b1, 32'h8000_0000, 32'h1111_1111, 4'hF, 0, rd, er, lt);
    xact(0, 1'b1, 32'h8000_0004, 32'h2222_2222, 4'hF, 0, rd, er, lt);
    xact(0, 1'b1, 32'h8000_0003, 32'h0000_FFFF, 4'h3, 0, rd, er, lt);
    check("cross_err", 32'(er), 32'd1);
    check("cross_rdata", rd, 32'd0);
    xact(0, 1'b0, 32'h8000_0000, 32'd0, 4'h0, 0, rd, er, lt);
    check("cross_w0", rd, 32'h1111_1111);
    xact(0, 1'b0, 32'h8000_0004, 32'd0, 4'h0, 0, rd, er, lt);
    check("cross_w4", rd, 32'h2222_2222);

    // Empty mask is a clean no-op
    xact(0, 1'b1, 32'h8000_0004, 32'hFFFF_FFFF, 4'h0, 0, rd, er, lt);
    check("nomask_err", 32'(er), 32'd0);
    xact(0, 1'b0, 32'h8000_0004, 32'd0, 4'h0, 0, rd, er, lt);
    check("nomask_w4", rd, 32'h2222_2222);

    // Response backpressure
    xact(0, 1'b0, 32'h8000_0010, 32'd0, 4'h0, 5, rd, er, lt);
    check("bp_rdata", rd, 32'hDEAD_BEEF);
    check("bp_lat", 32'(lt), 32'd3);

    // LATENCY=0, back-to-back with rsp_ready held high
    xact(1, 1'b1, 32'h8000_0100, 32'hA5A5_5A5A, 4'hF, 0, rd, er, lt);
    check("l0_wr_lat", 32'(lt), 32'd1);
    xact(1, 1'b0, 32'h8000_0100, 32'd0, 4'h0, 0, rd, er, lt);
    check("l0_rd_lat", 32'(lt), 32'd1);
    check("l0_rd", rd, 32'hA5A5_5A5A);
    xact(1, 1'b0, 32'h8000_0102, 32'd0, 4'h0, 0, rd, er, lt);
    check("l0_rd2_lat", 32'(lt), 32'd1);
    check("l0_rd2", rd, 32'h0000_A5A5);

    // LATENCY=15
    xact(2, 1'b1, 32'h8000_0200, 32'h0F1E_2D3C, 4'hF, 0, rd, er, lt);
    check("l15_wr_lat", 32'(lt), 32'd16);
    xact(2, 1'b0, 32'h8000_0200, 32'd0, 4'h0, 0, rd, er, lt);
    check("l15_rd_lat", 32'(lt), 32'd16);
    check("l15_rd", rd, 32'h0F1E_2D3C);

    // Async reset while a write is waiting
    xact(0, 1'b1, 32'h8000_0040, 32'h1122_3344, 4'hF, 0, rd, er, lt);
    xact(0, 1'b0, 32'h8000_0040, 32'd0, 4'h0, 0, rd, er, lt);
    check("pre_rst_rd40", rd, 32'h1122_3344);
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_wen[0]   = 1'b1;
    req_addr[0]  = 32'h8000_0040;
    req_wdata[0] = 32'hAABB_CCDD;
    req_wmask[0] = 4'hF;
    rsp_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    check("wait_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    #2;
    rst[0] = 1'b1;
    #1;
    check("arst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    check("arst_req_ready", 32'(req_ready[0]), 32'd0);
    check("arst_rsp_rdata", rsp_rdata[0], 32'd0);
    check("arst_rsp_err",   32'(rsp_err[0]), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst[0] = 1'b0;
    xact(0, 1'b0, 32'h8000_0040, 32'd0, 4'h0, 0, rd, er, lt);
    check("post_rst_rd40", rd, 32'h1122_3344);
    check("post_rst_err", 32'(er), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
